// File: rtl/reg_writeback.sv
// reg_writeback
//   Writer side of the register-file write port. Results from the load/store
//   unit (MEM) and the ALU are accepted through valid/ready handshakes,
//   buffered in a small in-order FIFO and drained into a registered
//   register-file write port at one write per cycle. Two combinational
//   forwarding lookups let decode see writes not yet in the register file.
//
//   Optional feature: define WB_STATS_EN to add the stall_cnt output, a
//   saturating count of cycles in which a valid producer was back-pressured.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   mem_valid/ready/addr/data       MEM result handshake (older of the pair)
//   alu_valid/ready/addr/data       ALU result handshake
//   rf_wrt, rf_addr, rf_d           registered register-file write port
//   fwd_addr_a/b                    forwarding lookup addresses
//   fwd_hit_a/b, fwd_data_a/b       lookup result (youngest pending data)
//   count                           FIFO occupancy, output register excluded
//   stall_cnt                       (WB_STATS_EN only) back-pressure cycles
module reg_writeback #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           mem_valid,
  output logic                           mem_ready,
  input  logic [ADDR_WIDTH-1:0]          mem_addr,
  input  logic [DATA_WIDTH-1:0]          mem_data,
  input  logic                           alu_valid,
  output logic                           alu_ready,
  input  logic [ADDR_WIDTH-1:0]          alu_addr,
  input  logic [DATA_WIDTH-1:0]          alu_data,
  output logic                           rf_wrt,
  output logic [ADDR_WIDTH-1:0]          rf_addr,
  output logic [DATA_WIDTH-1:0]          rf_d,
  input  logic [ADDR_WIDTH-1:0]          fwd_addr_a,
  input  logic [ADDR_WIDTH-1:0]          fwd_addr_b,
  output logic                           fwd_hit_a,
  output logic                           fwd_hit_b,
  output logic [DATA_WIDTH-1:0]          fwd_data_a,
  output logic [DATA_WIDTH-1:0]          fwd_data_b,
  output logic [$clog2(DEPTH+1)-1:0]     count
`ifdef WB_STATS_EN
  ,
  output logic [15:0]                    stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  // FIFO storage; no reset needed, liveness is tracked by the pointers/count.
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]         count_reg, count_next;
  logic                  rf_wrt_reg, rf_wrt_next;
  logic [ADDR_WIDTH-1:0] rf_addr_reg, rf_addr_next;
  logic [DATA_WIDTH-1:0] rf_d_reg, rf_d_next;

  logic [CW-1:0]         free;
  logic                  mem_w, alu_w;
  logic                  pop;
  logic                  w0_v, w1_v;
  logic [ADDR_WIDTH-1:0] w0_addr;
  logic [DATA_WIDTH-1:0] w0_data;
  logic                  enq0_v, enq1_v;
  logic [ADDR_WIDTH-1:0] enq0_addr;
  logic [DATA_WIDTH-1:0] enq0_data;

  assign free      = CW'(DEPTH) - count_reg;
  assign mem_ready = (free != '0);
  // The ALU needs a second free slot only when MEM competes in the same cycle.
  assign alu_ready = (free >= CW'(2)) || ((free != '0) && !mem_valid);

  // Accepted writes that actually reach the register file (address 0 dropped).
  assign mem_w = mem_valid && mem_ready && (mem_addr != '0);
  assign alu_w = alu_valid && alu_ready && (alu_addr != '0);

  // w0 is the oldest accepted write this cycle; w1 (always the ALU) exists
  // only when both sources deliver.
  assign w0_v    = mem_w || alu_w;
  assign w1_v    = mem_w && alu_w;
  assign w0_addr = mem_w ? mem_addr : alu_addr;
  assign w0_data = mem_w ? mem_data : alu_data;

  assign pop = (count_reg != '0);

  always_comb begin
    rf_wrt_next  = 1'b0;
    rf_addr_next = rf_addr_reg;
    rf_d_next    = rf_d_reg;
    enq0_v       = 1'b0;
    enq0_addr    = w0_addr;
    enq0_data    = w0_data;
    enq1_v       = 1'b0;
    if (pop) begin
      // Queued writes are older than anything arriving now.
      rf_wrt_next  = 1'b1;
      rf_addr_next = addr_mem[rd_ptr_reg];
      rf_d_next    = data_mem[rd_ptr_reg];
      enq0_v       = w0_v;
      enq1_v       = w1_v;
    end else if (w0_v) begin
      // Empty FIFO: bypass the oldest new write, queue the younger one.
      rf_wrt_next  = 1'b1;
      rf_addr_next = w0_addr;
      rf_d_next    = w0_data;
      enq0_v       = w1_v;
      enq0_addr    = alu_addr;
      enq0_data    = alu_data;
    end
  end

  assign wr_ptr_next = wr_ptr_reg + PW'(enq0_v) + PW'(enq1_v);
  assign rd_ptr_next = rd_ptr_reg + PW'(pop);
  assign count_next  = count_reg + CW'(enq0_v) + CW'(enq1_v) - CW'(pop);

  always_ff @(posedge clk) begin
    if (enq0_v) begin
      addr_mem[wr_ptr_reg] <= enq0_addr;
      data_mem[wr_ptr_reg] <= enq0_data;
    end
    if (enq1_v) begin
      addr_mem[wr_ptr_reg + PW'(1)] <= alu_addr;
      data_mem[wr_ptr_reg + PW'(1)] <= alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      rf_wrt_reg  <= 1'b0;
      rf_addr_reg <= '0;
      rf_d_reg    <= '0;
    end else begin
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      count_reg   <= count_next;
      rf_wrt_reg  <= rf_wrt_next;
      rf_addr_reg <= rf_addr_next;
      rf_d_reg    <= rf_d_next;
    end
  end

  assign rf_wrt  = rf_wrt_reg;
  assign rf_addr = rf_addr_reg;
  assign rf_d    = rf_d_reg;
  assign count   = count_reg;

  // Forwarding: two identical lookups. The output register is the oldest
  // pending write, so it is considered first and any live FIFO match
  // (scanned oldest to newest) overrides it, leaving the youngest match.
  logic [ADDR_WIDTH-1:0] fwd_addr [2];
  assign fwd_addr[0] = fwd_addr_a;
  assign fwd_addr[1] = fwd_addr_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic                  hit;
      logic [DATA_WIDTH-1:0] dat;
      always_comb begin
        hit = 1'b0;
        dat = '0;
        if (fwd_addr[gi] != '0) begin
          if (rf_wrt_reg && (rf_addr_reg == fwd_addr[gi])) begin
            hit = 1'b1;
            dat = rf_d_reg;
          end
          for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_reg) &&
                (addr_mem[rd_ptr_reg + PW'(i)] == fwd_addr[gi])) begin
              hit = 1'b1;
              dat = data_mem[rd_ptr_reg + PW'(i)];
            end
          end
        end
      end
    end
  endgenerate

  assign fwd_hit_a  = g_fwd[0].hit;
  assign fwd_data_a = g_fwd[0].dat;
  assign fwd_hit_b  = g_fwd[1].hit;
  assign fwd_data_b = g_fwd[1].dat;

`ifdef WB_STATS_EN
  logic        stall;
  logic [15:0] stall_cnt_reg;

  assign stall = (mem_valid && !mem_ready) || (alu_valid && !alu_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback
//   Self-checking bench for reg_writeback. The driver presents MEM/ALU
//   results and, after each cycle, pushes every accepted non-zero write into
//   a scoreboard queue in age order (MEM before ALU). A monitor on the
//   falling edge treats the queue as the set of pending writes: the head is
//   what the register-file port must show, the rest is the expected FIFO
//   contents, from which count, readies and forwarding results follow.
module tb_reg_writeback;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          mv = 1'b0, av = 1'b0;
  logic [AW-1:0] ma = '0, aa = '0, fa = '0, fb = '0;
  logic [DW-1:0] md = '0, ad = '0;

  logic          mem_ready, alu_ready, rf_wrt, fwd_hit_a, fwd_hit_b;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_d, fwd_data_a, fwd_data_b;
  logic [$clog2(DEPTH+1)-1:0] count;
`ifdef WB_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  reg_writeback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mv), .mem_ready(mem_ready), .mem_addr(ma), .mem_data(md),
    .alu_valid(av), .alu_ready(alu_ready), .alu_addr(aa), .alu_data(ad),
    .rf_wrt(rf_wrt), .rf_addr(rf_addr), .rf_d(rf_d),
    .fwd_addr_a(fa), .fwd_addr_b(fb),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
    .count(count)
`ifdef WB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;
  logic          out_v  = 1'b0;
  logic [AW-1:0] out_a  = '0;
  logic [DW-1:0] out_d  = '0;
  int            max_cnt = 0;
  int            writes  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Youngest pending write to x: the register-file port is the oldest
  // pending write, later queue entries are progressively younger.
  function automatic void fwd_model(input logic [AW-1:0] x, output logic hit,
                                    output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (x != '0) begin
      if (out_v && out_a == x) begin
        hit = 1'b1;
        d   = out_d;
      end
      foreach (exp_q[i]) begin
        if (exp_q[i].a == x) begin
          hit = 1'b1;
          d   = exp_q[i].d;
        end
      end
    end
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      wr_t           e;
      logic          eh;
      logic [DW-1:0] ed;
      int            free;
      out_v = (exp_q.size() != 0);
      if (out_v) begin
        e     = exp_q.pop_front();
        out_a = e.a;
        out_d = e.d;
        writes++;
        $display("rf write %0d: addr=%0d data=%08h (dut addr=%0d data=%08h)",
                 writes, out_a, out_d, rf_addr, rf_d);
      end
      chk("rf_wrt", rf_wrt, out_v);
      chk("rf_addr", rf_addr, out_a);
      chk("rf_d", rf_d, out_d);
      chk("count", count, exp_q.size());
      if (exp_q.size() > max_cnt) max_cnt = exp_q.size();
      free = DEPTH - exp_q.size();
      chk("mem_ready", mem_ready, free >= 1);
      chk("alu_ready", alu_ready, (free >= 2) || (free >= 1 && !mv));
      fwd_model(fa, eh, ed);
      chk("fwd_hit_a", fwd_hit_a, eh);
      chk("fwd_data_a", fwd_data_a, ed);
      fwd_model(fb, eh, ed);
      chk("fwd_hit_b", fwd_hit_b, eh);
      chk("fwd_data_b", fwd_data_b, ed);
    end
  end

  // One handshake cycle: inputs already driven (posedge+1). Record accepted
  // writes after the monitor has sampled, then retire accepted producers.
  task automatic run_cycle();
    logic acc_m, acc_a;
    @(negedge clk);
    #2;
    acc_m = mv && mem_ready;
    acc_a = av && alu_ready;
    if (acc_m && ma != '0) exp_q.push_back('{a: ma, d: md});
    if (acc_a && aa != '0) exp_q.push_back('{a: aa, d: ad});
    @(posedge clk);
    #1;
    if (acc_m) mv = 1'b0;
    if (acc_a) av = 1'b0;
  endtask

  task automatic send(input logic m_v, input logic [AW-1:0] m_a, input logic [DW-1:0] m_d,
                      input logic a_v, input logic [AW-1:0] a_a, input logic [DW-1:0] a_d);
    mv = m_v; ma = m_a; md = m_d;
    av = a_v; aa = a_a; ad = a_d;
    for (int k = 0; k < 50 && (mv || av); k++) run_cycle();
    chk("send_timeout", mv || av, 1'b0);
    mv = 1'b0;
    av = 1'b0;
  endtask

  task automatic idle(input int n);
    mv = 1'b0;
    av = 1'b0;
    repeat (n) run_cycle();
  endtask

  initial begin
    int nxt;
    // Reset state.
    #2;
    chk("reset_rf_wrt", rf_wrt, 1'b0);
    chk("reset_count", count, 0);
    chk("reset_rf_addr", rf_addr, 0);
    #10 rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Single ALU write into an empty FIFO is bypassed straight to the port.
    send(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h12345678);
    chk("t1_rf_wrt", rf_wrt, 1'b1);
    chk("t1_rf_addr", rf_addr, 6);
    chk("t1_rf_d", rf_d, 32'h12345678);
    idle(2);

    // Address 0 is accepted but never written or forwarded.
    fa = '0;
    send(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h00004541);
    idle(3);

    // Same-cycle pair: MEM first, ALU queued behind it.
    send(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB);
    chk("t3_rf_addr", rf_addr, 3);
    chk("t3_count", count, 1);
    idle(3);

    // Sustained dual-source burst, addresses 1..16. A pop happens every
    // cycle the FIFO is non-empty, so occupancy peaks one below DEPTH.
    max_cnt = 0;
    nxt = 1;
    for (int k = 0; k < 60 && (nxt <= 16 || mv || av); k++) begin
      if (!mv && nxt <= 16) begin mv = 1'b1; ma = AW'(nxt); md = $urandom; nxt++; end
      if (!av && nxt <= 16) begin av = 1'b1; aa = AW'(nxt); ad = $urandom; nxt++; end
      run_cycle();
    end
    chk("burst_done", (nxt <= 16) || mv || av, 1'b0);
    chk("burst_peak_count", max_cnt, DEPTH - 1);
    idle(8);

    // Forwarding picks the younger of two same-address writes.
    fa = 5'd7;
    fb = 5'd9;
    send(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h202);
    send(1'b1, 5'd3, 32'h303, 1'b1, 5'd4, 32'h404);
    send(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
    chk("t5_count", count, 3);
    chk("t5_rf_wrt", rf_wrt, 1'b1);
    chk("t5_hit_a", fwd_hit_a, 1'b1);
    chk("t5_data_a", fwd_data_a, 32'h22);
    chk("t5_hit_b", fwd_hit_b, 1'b0);
    chk("t5_data_b", fwd_data_b, 0);

    // Asynchronous reset mid-cycle with writes pending.
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async_rf_wrt", rf_wrt, 1'b0);
    chk("async_count", count, 0);
    chk("async_hit_a", fwd_hit_a, 1'b0);
    exp_q.delete();
    out_a = '0;
    out_d = '0;
    mv = 1'b0;
    av = 1'b0;
    @(negedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(6);

    // Randomized traffic over a small address space to provoke hits.
    for (int k = 0; k < 300; k++) begin
      if (!mv && ($urandom % 4) != 0) begin mv = 1'b1; ma = AW'($urandom % 8); md = $urandom; end
      if (!av && ($urandom % 4) != 0) begin av = 1'b1; aa = AW'($urandom % 8); ad = $urandom; end
      fa = AW'($urandom % 8);
      fb = AW'($urandom % 8);
      run_cycle();
    end
    idle(10);
    chk("final_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
